// File: rtl/wbupsize_pkg.sv
// wbupsize_pkg: default bus geometry and lane-count helper for the Wishbone upsizer
package wbupsize_pkg;
    localparam int DEF_SDW    = 32;
    localparam int DEF_MDW    = 128;
    localparam int DEF_MAW    = 24;
    localparam int DEF_LGFIFO = 5;
    function automatic int lane_bits(input int sdw, input int mdw);
        return $clog2(mdw / sdw);
    endfunction
endpackage

// File: rtl/wbupsize_sfifo.sv
// sfifo: synchronous FIFO of lane indices, first-word fall-through read data
//   i_push/i_data write when not full; i_pop drops the head when not empty
//   i_flush empties the FIFO; o_full/o_empty/o_count report occupancy
module sfifo #(
    parameter int BW = 2,
    parameter int LG = 5
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [BW-1:0] i_data,
    input  logic          i_pop,
    output logic [BW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [LG:0]   o_count
);
    logic [BW-1:0] r_mem [0:(1<<LG)-1];
    logic [LG-1:0] r_wr, r_rd;
    logic [LG:0]   r_cnt;
    logic          w_push, w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_cnt[LG];
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge i_clk)
        if (w_push) r_mem[r_wr] <= i_data;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr + LG'(w_push);
            r_rd  <= r_rd + LG'(w_pop);
            r_cnt <= r_cnt + (LG+1)'(w_push) - (LG+1)'(w_pop);
        end
    end
endmodule

// File: rtl/wbupsize.sv
// wbupsize: pipelined Wishbone upsizer, narrow CPU slave port to wide SDRAM master port
//   i_wb_*  : slave side, SDW-bit data, SAW-bit word address
//   o_mwb_* : master side, MDW-bit data, MAW-bit word address, one request in flight on stb
//   Lane indices of outstanding requests are queued so read data is picked from the right lane.
module wbupsize
    import wbupsize_pkg::*;
#(
    parameter  int SDW    = DEF_SDW,
    parameter  int MDW    = DEF_MDW,
    parameter  int MAW    = DEF_MAW,
    parameter  int LGFIFO = DEF_LGFIFO,
    localparam int K      = lane_bits(SDW, MDW),
    localparam int SAW    = MAW + K
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [SAW-1:0]   i_wb_addr,
    input  logic [SDW-1:0]   i_wb_data,
    input  logic [SDW/8-1:0] i_wb_sel,
    output logic             o_wb_stall,
    output logic             o_wb_ack,
    output logic             o_wb_err,
    output logic [SDW-1:0]   o_wb_data,
    output logic             o_mwb_cyc,
    output logic             o_mwb_stb,
    output logic             o_mwb_we,
    output logic [MAW-1:0]   o_mwb_addr,
    output logic [MDW-1:0]   o_mwb_data,
    output logic [MDW/8-1:0] o_mwb_sel,
    input  logic             i_mwb_stall,
    input  logic             i_mwb_ack,
    input  logic             i_mwb_err,
    input  logic [MDW-1:0]   i_mwb_data
);
    localparam int NL = MDW / SDW;
    localparam int SB = SDW / 8;

    logic             w_accept, w_full, w_empty, w_pop, w_err, w_flush, w_stb_n;
    logic [K-1:0]     w_lane, w_head;
    logic [LGFIFO:0]  w_cnt, w_cnt_n;
    logic [MDW/8-1:0] w_sel;
    logic             r_errp;

    assign o_wb_stall = (o_mwb_stb && i_mwb_stall) || w_full || r_errp;
    assign w_accept   = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign w_lane     = i_wb_addr[K-1:0];
    assign w_pop      = o_mwb_cyc && i_mwb_ack && !w_empty;
    assign w_err      = o_mwb_cyc && i_mwb_err;
    assign w_flush    = !i_wb_cyc || w_err;
    assign w_stb_n    = w_accept || (o_mwb_stb && i_mwb_stall);
    assign w_cnt_n    = w_cnt + (LGFIFO+1)'(w_accept) - (LGFIFO+1)'(w_pop);

    for (genvar g = 0; g < NL; g++) begin : g_lane
        assign w_sel[g*SB +: SB] = (w_lane == K'(g)) ? i_wb_sel : '0;
    end

    sfifo #(.BW(K), .LG(LGFIFO)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (w_flush),
        .i_push  (w_accept),
        .i_data  (w_lane),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_cnt)
    );

    // cyc stays up while anything is queued or still being presented;
    // an error latches r_errp until the CPU closes its cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_mwb_cyc <= 1'b0;
            o_mwb_stb <= 1'b0;
            r_errp    <= 1'b0;
        end else if (w_flush) begin
            o_mwb_cyc <= 1'b0;
            o_mwb_stb <= 1'b0;
            r_errp    <= i_wb_cyc;
        end else begin
            o_mwb_stb <= w_stb_n;
            o_mwb_cyc <= w_stb_n || (w_cnt_n != '0);
        end
    end

    // acceptance only happens when not stalled, so these hold during a stall
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            o_mwb_addr <= i_wb_addr[SAW-1:K];
            o_mwb_data <= {NL{i_wb_data}};
            o_mwb_sel  <= w_sel;
            o_mwb_we   <= i_wb_we;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack <= i_wb_cyc && w_pop && !i_mwb_err;
            o_wb_err <= i_wb_cyc && w_err;
            if (w_pop) o_wb_data <= i_mwb_data[w_head*SDW +: SDW];
        end
    end
endmodule

// File: doc/wbupsize.md
WBUPSIZE -- requirements
Module: wbupsize

Interface
REQ-001 Parameter SDW, default 32, slave (CPU-side) Wishbone data width in bits.
REQ-002 Parameter MDW, default 128, master (SDRAM-side) Wishbone data width; MDW = SDW*2^k, k>=1.
REQ-003 Parameter MAW, default 24, master word-address width; slave address width SAW = MAW+log2(MDW/SDW).
REQ-004 Parameter LGFIFO, default 5, log2 depth of the outstanding-request FIFO.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-006 i_clk  input  1  system clock (the memory controller's user-interface clock).
REQ-007 i_reset  input  1  synchronous active-high reset.
REQ-008 i_wb_cyc, i_wb_stb, i_wb_we  input  1 each  slave Wishbone pipelined control.
REQ-009 i_wb_addr  input  SAW  slave word address.
REQ-010 i_wb_data  input  SDW  slave write data.
REQ-011 i_wb_sel  input  SDW/8  slave byte selects.
REQ-012 o_wb_stall, o_wb_ack, o_wb_err  output  1 each  slave responses.
REQ-013 o_wb_data  output  SDW  slave read data.
REQ-014 o_mwb_cyc, o_mwb_stb, o_mwb_we  output  1 each  master control toward the SDRAM bridge.
REQ-015 o_mwb_addr  output  MAW  master word address.
REQ-016 o_mwb_data  output  MDW  master write data.
REQ-017 o_mwb_sel  output  MDW/8  master byte selects.
REQ-018 i_mwb_stall, i_mwb_ack, i_mwb_err  input  1 each  master responses.
REQ-019 i_mwb_data  input  MDW  master read data.

Function
REQ-020 Request accepted when i_wb_stb && !o_wb_stall; o_wb_stall = o_mwb_stb && i_mwb_stall, OR FIFO full, OR err_pending.
REQ-021 On acceptance, the next cycle sets o_mwb_stb=1 (one-cycle registered latency), with o_mwb_addr = i_wb_addr[SAW-1:SAW-MAW] and lane L = i_wb_addr[low k bits].
REQ-022 o_mwb_data = i_wb_data replicated across all lanes; o_mwb_sel = i_wb_sel in lane L, zeros elsewhere; lane 0 = least significant bits.
REQ-023 o_mwb_stb/addr/data/sel/we hold stable while o_mwb_stb && i_mwb_stall; o_mwb_stb clears when the request is accepted and no new request is taken.
REQ-024 Lane L is pushed into the FIFO on every acceptance; FIFO holds at most 2^LGFIFO entries; full stalls the slave.
REQ-025 On i_mwb_ack, pop the FIFO; the next cycle o_wb_ack=1 and o_wb_data = lane (popped L) of i_mwb_data, registered.
REQ-026 Push and pop in the same cycle leave the count unchanged; an ack with an empty FIFO is ignored.
REQ-027 o_mwb_cyc = i_wb_cyc && !err_pending, registered, going high the cycle o_mwb_stb first rises and staying high while the FIFO is non-empty or o_mwb_stb is high.
REQ-028 i_wb_cyc low: next cycle o_mwb_cyc=0, o_mwb_stb=0, FIFO flushed; subsequent i_mwb_ack ignored, no o_wb_ack.
REQ-029 i_mwb_err while o_mwb_cyc: next cycle o_wb_err=1 for one cycle, o_mwb_cyc=0, o_mwb_stb=0, FIFO flushed, err_pending=1 until i_wb_cyc drops.
REQ-030 o_wb_ack and o_wb_err are never asserted together, and are never asserted while i_wb_cyc was low the previous cycle.

Reset
REQ-031 Reset forces o_mwb_cyc=0, o_mwb_stb=0, o_wb_ack=0, o_wb_err=0, o_wb_data=0, FIFO empty, err_pending=0; mid-transaction, all outstanding acks are discarded.
REQ-032 o_mwb_addr/data/sel/we are don't-care while o_mwb_stb=0.

Structure
REQ-033 The lane-index FIFO SHALL be one sub-module, sfifo (width k, depth 2^LGFIFO, synchronous reset, full/empty flags).
REQ-034 The lane-count constant k=log2(MDW/SDW) SHALL be a local parameter; no shared package is required.

Verification
REQ-035 Single write, addr 0x000003, data 0xDEADBEEF, sel 0xF -> o_mwb_addr 0x000000, sel 0xF000, lane-3 data 0xDEADBEEF.
REQ-036 Four pipelined reads to addrs 0..3, with the master returning 128'h4444_4444_3333_3333_2222_2222_1111_1111 per ack -> four o_wb_acks with data 0x11111111, 0x22222222, 0x33333333, 0x44444444 in order.
REQ-037 Master stall held 3 cycles with 33 requests issued (LGFIFO=5) -> master outputs stable during the stall; o_wb_stall asserts with 32 outstanding; no request is lost.
REQ-038 i_mwb_err on the 2nd of 3 reads -> one o_wb_err, o_mwb_cyc=0 next cycle, no further acks, stall until i_wb_cyc drops.
REQ-039 i_wb_cyc dropped with 2 outstanding, then late i_mwb_acks -> no o_wb_ack; FIFO empty; a new cycle works normally.
REQ-040 i_reset pulsed with 3 outstanding -> all outputs zero next cycle; a following write completes correctly.
